// File: rtl/vtisa_prog_loader.sv
// Boot-time program loader: receives a length-prefixed, checksummed byte stream
// from asynchronous pins, writes it to instruction memory, then releases the CPU.
module vtisa_prog_loader #(
    parameter int ADDR_W    = 5,
    parameter int TIMEOUT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_req,
    input  logic [7:0]        byte_in,
    input  logic              byte_stb,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              cpu_run,
    output logic              busy,
    output logic              err,
    output logic [1:0]        err_code
);

    localparam int LEN_W = ADDR_W + 1;
    localparam logic [TIMEOUT_W-1:0] TMO_LAST = {TIMEOUT_W{1'b1}} - TIMEOUT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_DATA,
        S_CSUM,
        S_RUN,
        S_ERR
    } state_t;

    state_t               state_reg, state_next;
    logic [2:0]           sync_reg;
    logic [7:0]           data_reg;
    logic                 accept;
    logic [LEN_W-1:0]     len_reg, len_next;
    logic [LEN_W-1:0]     addr_reg, addr_next;
    logic [7:0]           sum_reg, sum_next;
    logic [TIMEOUT_W-1:0] tmo_reg, tmo_next;
    logic [1:0]           err_code_reg, err_code_next;
    logic                 we_reg, we_next;
    logic [ADDR_W-1:0]    waddr_reg, waddr_next;
    logic [7:0]           wdata_reg, wdata_next;
    logic [ADDR_W-1:0]    len_low;
    logic [LEN_W-1:0]     len_val;
    logic [LEN_W-1:0]     addr_inc;
    logic [7:0]           sum_add;
    logic                 tmo_hit;
    logic                 in_load;

    // byte_in is sampled one cycle behind the strobe pipeline so the value used at
    // the accept edge was taken while the strobe was still guaranteed high.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_reg <= '0;
            data_reg <= '0;
        end else begin
            sync_reg <= {sync_reg[1:0], byte_stb};
            data_reg <= byte_in;
        end
    end

    assign accept   = sync_reg[1] & ~sync_reg[2];
    assign in_load  = (state_reg == S_LEN) || (state_reg == S_DATA) || (state_reg == S_CSUM);
    assign len_low  = ADDR_W'(data_reg);
    assign len_val  = (len_low == '0) ? {1'b1, {ADDR_W{1'b0}}} : {1'b0, len_low};
    assign addr_inc = addr_reg + LEN_W'(1);
    assign sum_add  = sum_reg + data_reg;
    assign tmo_hit  = in_load && (tmo_reg == TMO_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= S_IDLE;
            len_reg      <= '0;
            addr_reg     <= '0;
            sum_reg      <= '0;
            tmo_reg      <= '0;
            err_code_reg <= '0;
            we_reg       <= 1'b0;
            waddr_reg    <= '0;
            wdata_reg    <= '0;
        end else begin
            state_reg    <= state_next;
            len_reg      <= len_next;
            addr_reg     <= addr_next;
            sum_reg      <= sum_next;
            tmo_reg      <= tmo_next;
            err_code_reg <= err_code_next;
            we_reg       <= we_next;
            waddr_reg    <= waddr_next;
            wdata_reg    <= wdata_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        len_next      = len_reg;
        addr_next     = addr_reg;
        sum_next      = sum_reg;
        tmo_next      = in_load ? tmo_reg + TIMEOUT_W'(1) : '0;
        err_code_next = err_code_reg;
        we_next       = 1'b0;
        waddr_next    = waddr_reg;
        wdata_next    = wdata_reg;

        case (state_reg)
            S_IDLE, S_RUN, S_ERR: begin
                if (load_req) begin
                    state_next    = S_LEN;
                    err_code_next = 2'b00;
                    tmo_next      = '0;
                end
            end
            S_LEN: begin
                if (accept) begin
                    len_next   = len_val;
                    addr_next  = '0;
                    sum_next   = '0;
                    tmo_next   = '0;
                    state_next = S_DATA;
                end else if (tmo_hit) begin
                    state_next    = S_ERR;
                    err_code_next = 2'b10;
                end
            end
            S_DATA: begin
                if (accept) begin
                    we_next    = 1'b1;
                    waddr_next = addr_reg[ADDR_W-1:0];
                    wdata_next = data_reg;
                    sum_next   = sum_add;
                    addr_next  = addr_inc;
                    tmo_next   = '0;
                    // Counter is one bit wider than the address so a full image ends cleanly.
                    if (addr_inc == len_reg)
                        state_next = S_CSUM;
                end else if (tmo_hit) begin
                    state_next    = S_ERR;
                    err_code_next = 2'b10;
                end
            end
            S_CSUM: begin
                if (accept) begin
                    tmo_next = '0;
                    if (sum_add == 8'h00) begin
                        state_next = S_RUN;
                    end else begin
                        state_next    = S_ERR;
                        err_code_next = 2'b01;
                    end
                end else if (tmo_hit) begin
                    state_next    = S_ERR;
                    err_code_next = 2'b10;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign mem_we    = we_reg;
    assign mem_addr  = waddr_reg;
    assign mem_wdata = wdata_reg;
    assign cpu_run   = (state_reg == S_RUN);
    assign busy      = in_load;
    assign err       = (state_reg == S_ERR);
    assign err_code  = err_code_reg;

endmodule

// File: tb/tb_vtisa_prog_loader.sv
// Scoreboard bench for vtisa_prog_loader: expected memory writes are queued as
// bytes are sent and popped when mem_we is observed.
module tb_vtisa_prog_loader;

    localparam int ADDR_W = 5;
    localparam int TW     = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              load_req;
    logic [7:0]        byte_in;
    logic              byte_stb;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic              cpu_run;
    logic              busy;
    logic              err;
    logic [1:0]        err_code;

    vtisa_prog_loader #(.ADDR_W(ADDR_W), .TIMEOUT_W(TW)) dut (
        .clk       (clk),
        .rst       (rst),
        .load_req  (load_req),
        .byte_in   (byte_in),
        .byte_stb  (byte_stb),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_run   (cpu_run),
        .busy      (busy),
        .err       (err),
        .err_code  (err_code)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int addr;
        int data;
        int when;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_e;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h cyc=%0d", tag, got, exp, cyc);
        end
    endtask

    // mem_we is registered one edge after the accept, which is two edges after
    // the first strobe sample, so it is seen on the negedge following edge e0+2.
    always @(negedge clk) begin
        if (mem_we !== 1'b0) begin
            if (exp_q.size() == 0) begin
                check("unexp_we", {31'd0, mem_we}, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                $display("write addr=%0d data=%02h cyc=%0d (exp addr=%0d data=%02h cyc=%0d)",
                         mem_addr, mem_wdata, cyc, mon_e.addr, mon_e.data, mon_e.when);
                check("wr_addr", 32'(mem_addr), 32'(mon_e.addr));
                check("wr_data", 32'(mem_wdata), 32'(mon_e.data));
                check("wr_cyc", 32'(cyc), 32'(mon_e.when));
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit wr, input int a, output int acc);
        int e0;
        @(negedge clk);
        byte_in = b;
        @(negedge clk);
        byte_stb = 1'b1;
        e0  = cyc + 1;
        acc = e0 + 2;
        if (wr) exp_q.push_back('{a, int'(b), e0 + 2});
        repeat (2) @(negedge clk);
        byte_stb = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic load_stream(input logic [7:0] s[$], output int acc);
        send_byte(s[0], 1'b0, 0, acc);
        for (int i = 1; i < s.size() - 1; i++)
            send_byte(s[i], 1'b1, i - 1, acc);
        send_byte(s[s.size() - 1], 1'b0, 0, acc);
    endtask

    task automatic pulse_load(input string tag);
        @(negedge clk);
        load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
        $display("load_req %s busy=%0b cpu_run=%0b err=%0b", tag, busy, cpu_run, err);
        check({tag, "_busy"}, {31'd0, busy}, 32'd1);
        check({tag, "_run"}, {31'd0, cpu_run}, 32'd0);
        check({tag, "_err"}, {31'd0, err}, 32'd0);
        check({tag, "_code"}, {30'd0, err_code}, 32'd0);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_run"}, {31'd0, cpu_run}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_err"}, {31'd0, err}, 32'd0);
        check({tag, "_code"}, {30'd0, err_code}, 32'd0);
        check({tag, "_addr"}, 32'(mem_addr), 32'd0);
        check({tag, "_wdata"}, 32'(mem_wdata), 32'd0);
    endtask

    logic [7:0] good_s[$];
    logic [7:0] bad_s[$];
    logic [7:0] full_s[$];

    initial begin
        int acc;
        logic [7:0] sum;

        rst      = 1'b1;
        load_req = 1'b0;
        byte_in  = 8'h5A;
        byte_stb = 1'b0;

        // Reset with strobes toggling: nothing may be written.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            byte_stb = ~byte_stb;
        end
        check("rst_we", {31'd0, mem_we}, 32'd0);
        check_idle("rst");
        @(negedge clk);
        rst      = 1'b0;
        byte_stb = 1'b0;
        repeat (3) @(negedge clk);
        check_idle("post_rst");

        // Strobe in IDLE is ignored.
        send_byte(8'h77, 1'b0, 0, acc);
        check("idle_busy", {31'd0, busy}, 32'd0);

        good_s = '{8'h03, 8'h11, 8'h22, 8'h33, 8'h9A};
        bad_s  = '{8'h03, 8'h11, 8'h22, 8'h33, 8'h00};

        // Good load.
        pulse_load("good");
        load_stream(good_s, acc);
        $display("good load cpu_run=%0b err=%0b", cpu_run, err);
        check("good_run", {31'd0, cpu_run}, 32'd1);
        check("good_err", {31'd0, err}, 32'd0);
        check("good_busy", {31'd0, busy}, 32'd0);
        check("good_q", 32'(exp_q.size()), 32'd0);

        // Reload from RUN, bad checksum.
        pulse_load("reload");
        load_stream(bad_s, acc);
        $display("bad csum err=%0b code=%0b cpu_run=%0b", err, err_code, cpu_run);
        check("bad_err", {31'd0, err}, 32'd1);
        check("bad_code", {30'd0, err_code}, 32'd1);
        check("bad_run", {31'd0, cpu_run}, 32'd0);
        check("bad_q", 32'(exp_q.size()), 32'd0);

        // Recovery from ERR.
        pulse_load("recover");
        load_stream(good_s, acc);
        check("rec_run", {31'd0, cpu_run}, 32'd1);
        check("rec_code", {30'd0, err_code}, 32'd0);

        // Full image: length 0 means 32 bytes.
        full_s.push_back(8'h00);
        sum = 8'h00;
        for (int i = 0; i < 32; i++) begin
            full_s.push_back(8'(i));
            sum = sum + 8'(i);
        end
        full_s.push_back(8'h00 - sum);
        pulse_load("full");
        load_stream(full_s, acc);
        repeat (4) @(negedge clk);
        $display("full image cpu_run=%0b err=%0b", cpu_run, err);
        check("full_run", {31'd0, cpu_run}, 32'd1);
        check("full_err", {31'd0, err}, 32'd0);
        check("full_q", 32'(exp_q.size()), 32'd0);

        // Timeout: one data byte of four, then silence.
        pulse_load("tmo");
        send_byte(8'h04, 1'b0, 0, acc);
        send_byte(8'hA5, 1'b1, 0, acc);
        while (cyc < acc + 254) @(negedge clk);
        check("tmo_early", {31'd0, err}, 32'd0);
        @(negedge clk);
        $display("timeout cyc=%0d err=%0b code=%0b", cyc, err, err_code);
        check("tmo_err", {31'd0, err}, 32'd1);
        check("tmo_code", {30'd0, err_code}, 32'd2);
        check("tmo_busy", {31'd0, busy}, 32'd0);
        send_byte(8'h55, 1'b0, 0, acc);
        check("late_err", {31'd0, err}, 32'd1);
        check("tmo_q", 32'(exp_q.size()), 32'd0);

        // Abort by reset mid-image.
        pulse_load("abort");
        send_byte(8'h04, 1'b0, 0, acc);
        send_byte(8'hA1, 1'b1, 0, acc);
        send_byte(8'hB2, 1'b1, 1, acc);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check_idle("abort");
        send_byte(8'hC3, 1'b0, 0, acc);
        send_byte(8'hD4, 1'b0, 0, acc);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_q", 32'(exp_q.size()), 32'd0);

        repeat (4) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
